// File: rtl/pc_kbd_pkg.sv
// Shared types and constants for the XT keyboard receiver.
// Frame layout and timeout counter sizing live here.
package pc_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } kbd_state_t;

    localparam int   KBD_DATA_BITS = 8;
    localparam logic KBD_START_BIT = 1'b1;

    function automatic int tmo_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pc_kbd_line_filter.sv
// Synchroniser and glitch filter for one keyboard line.
// Emits the filtered level and a one-cycle strobe on its falling edge.
module pc_kbd_line_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          run_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain; idle keyboard lines float high.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end

    // Flip the level only after a full run of differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (synced == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_CYCLES - 1)) begin
                level   <= synced;
                run_cnt <= '0;
                fall    <= ~synced;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_kbd_xt_receiver.sv
// XT keyboard frame receiver feeding PPI port A and IRQ1.
// Obeys PB6 (clock hold) and PB7 (clear/acknowledge).
module pc_kbd_xt_receiver
    import pc_kbd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbd_clk_in,
    input  logic       kbd_data_in,
    input  logic       pb6_clk_enable,
    input  logic       pb7_clear,
    output logic [7:0] scancode,
    output logic       irq1,
    output logic       kbd_clk_oe,
    output logic       kbd_data_oe,
    output logic       frame_err
);

    localparam int TW = tmo_width(TIMEOUT_CYCLES);

    kbd_state_t               state, state_n;
    logic [2:0]               bit_cnt, bit_cnt_n;
    logic [KBD_DATA_BITS-1:0] shift, shift_n, scancode_n;
    logic [TW-1:0]            tmo_cnt, tmo_n;
    logic                     irq1_n, data_oe_n, frame_err_n;
    logic [SYNC_STAGES-1:0]   data_sync;
    logic                     clk_level, clk_fall;
    logic                     data_bit, sample;

    pc_kbd_line_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .line_in(kbd_clk_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    assign data_bit = data_sync[SYNC_STAGES-1];
    // While we hold the clock low ourselves, edges are not keyboard bits.
    assign sample   = clk_fall & ~clk_level & ~kbd_clk_oe;

    // Plain synchroniser for the data line.
    always_ff @(posedge clk) begin
        if (reset) data_sync <= '1;
        else       data_sync <= {data_sync[SYNC_STAGES-2:0], kbd_data_in};
    end

    // Frame FSM next-state and output decode.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        tmo_n       = tmo_cnt;
        scancode_n  = scancode;
        irq1_n      = irq1;
        data_oe_n   = kbd_data_oe;
        frame_err_n = 1'b0;
        if (pb7_clear) begin
            state_n    = IDLE;
            bit_cnt_n  = '0;
            shift_n    = '0;
            tmo_n      = '0;
            scancode_n = '0;
            irq1_n     = 1'b0;
            data_oe_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tmo_n = '0;
                    if (sample && data_bit == KBD_START_BIT) begin
                        state_n   = SHIFT;
                        bit_cnt_n = '0;
                    end
                end
                SHIFT: begin
                    if (sample) begin
                        shift_n   = {data_bit, shift[KBD_DATA_BITS-1:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        tmo_n     = '0;
                        if (bit_cnt == 3'(KBD_DATA_BITS - 1)) begin
                            scancode_n = {data_bit, shift[KBD_DATA_BITS-1:1]};
                            irq1_n     = 1'b1;
                            data_oe_n  = 1'b1;
                            state_n    = FULL;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_n     = IDLE;
                        shift_n     = '0;
                        bit_cnt_n   = '0;
                        tmo_n       = '0;
                        frame_err_n = 1'b1;
                    end else if (tmo_cnt != '1) begin
                        tmo_n = tmo_cnt + 1'b1;
                    end
                end
                FULL: begin
                    irq1_n    = 1'b1;
                    data_oe_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            tmo_cnt     <= '0;
            scancode    <= '0;
            irq1        <= 1'b0;
            kbd_data_oe <= 1'b0;
            frame_err   <= 1'b0;
            kbd_clk_oe  <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            tmo_cnt     <= tmo_n;
            scancode    <= scancode_n;
            irq1        <= irq1_n;
            kbd_data_oe <= data_oe_n;
            frame_err   <= frame_err_n;
            kbd_clk_oe  <= ~pb6_clk_enable;
        end
    end

endmodule

// File: tb/tb_pc_kbd_xt_receiver.sv
// Directed bench for the XT keyboard receiver.
// Frame table plus hand sequences for timeout, PB6 hold and reset.
module tb_pc_kbd_xt_receiver;
    import pc_kbd_pkg::*;

    localparam int FILT = 4;
    localparam int TMO  = 10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kbd_clk_in = 1'b1;
    logic       kbd_data_in = 1'b1;
    logic       pb6_clk_enable = 1'b1;
    logic       pb7_clear = 1'b0;
    logic [7:0] scancode;
    logic       irq1, kbd_clk_oe, kbd_data_oe, frame_err;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;
    int fe_base;

    typedef struct {
        logic [7:0] code;
        bit         lead_zero;
        bit         glitch;
        bit         extra_edges;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[5];

    pc_kbd_xt_receiver #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .kbd_clk_in    (kbd_clk_in),
        .kbd_data_in   (kbd_data_in),
        .pb6_clk_enable(pb6_clk_enable),
        .pb7_clear     (pb7_clear),
        .scancode      (scancode),
        .irq1          (irq1),
        .kbd_clk_oe    (kbd_clk_oe),
        .kbd_data_oe   (kbd_data_oe),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err) fe_count <= fe_count + 1;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic kbd_bit(input logic b);
        kbd_data_in = b;
        tick(10);
        kbd_clk_in = 1'b0;
        tick(10);
        kbd_clk_in = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit glitch);
        kbd_bit(1'b1);
        for (int i = 0; i < 8; i++) begin
            if (glitch && i == 3) begin
                kbd_clk_in = 1'b0;
                tick(FILT - 1);
                kbd_clk_in = 1'b1;
                tick(10);
                check("glitch_bit_cnt", 32'(dut.bit_cnt), 32'd3);
            end
            kbd_bit(code[i]);
        end
    endtask

    task automatic clear_pulse();
        pb7_clear = 1'b1;
        tick();
        pb7_clear = 1'b0;
        check("clr_irq1", 32'(irq1), 32'd0);
        check("clr_scancode", 32'(scancode), 32'h00);
        check("clr_data_oe", 32'(kbd_data_oe), 32'd0);
        check("clr_state", 32'(dut.state), 32'(IDLE));
        tick();
    endtask

    initial begin
        vecs[0] = '{code: 8'h1E, lead_zero: 0, glitch: 0, extra_edges: 1, exp_code: 8'h1E};
        vecs[1] = '{code: 8'h9E, lead_zero: 0, glitch: 0, extra_edges: 0, exp_code: 8'h9E};
        vecs[2] = '{code: 8'h1E, lead_zero: 1, glitch: 1, extra_edges: 0, exp_code: 8'h1E};
        vecs[3] = '{code: 8'h00, lead_zero: 0, glitch: 0, extra_edges: 0, exp_code: 8'h00};
        vecs[4] = '{code: 8'hFF, lead_zero: 1, glitch: 0, extra_edges: 0, exp_code: 8'hFF};

        tick(3);
        check("rst_scancode", 32'(scancode), 32'h00);
        check("rst_irq1", 32'(irq1), 32'd0);
        check("rst_clk_oe", 32'(kbd_clk_oe), 32'd0);
        check("rst_data_oe", 32'(kbd_data_oe), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].lead_zero) begin
                kbd_bit(1'b0);
                check("lead_zero_idle", 32'(dut.state), 32'(IDLE));
            end
            send_frame(vecs[v].code, vecs[v].glitch);
            check("frame_irq1", 32'(irq1), 32'd1);
            check("frame_scancode", 32'(scancode), 32'(vecs[v].exp_code));
            check("frame_data_oe", 32'(kbd_data_oe), 32'd1);
            if (vecs[v].extra_edges) begin
                for (int k = 0; k < 5; k++) kbd_bit(k[0]);
                check("full_hold_code", 32'(scancode), 32'(vecs[v].exp_code));
                check("full_hold_state", 32'(dut.state), 32'(FULL));
            end
            clear_pulse();
        end

        fe_base = fe_count;
        kbd_bit(1'b1);
        kbd_bit(1'b1);
        kbd_bit(1'b0);
        kbd_bit(1'b1);
        tick(TMO + 20);
        check("tmo_pulse_cycles", 32'(fe_count - fe_base), 32'd1);
        check("tmo_state", 32'(dut.state), 32'(IDLE));
        check("tmo_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        check("tmo_irq1", 32'(irq1), 32'd0);
        send_frame(8'h2A, 1'b0);
        check("tmo_next_code", 32'(scancode), 32'h2A);
        check("tmo_next_irq1", 32'(irq1), 32'd1);
        clear_pulse();

        pb6_clk_enable = 1'b0;
        tick();
        check("pb6_clk_oe", 32'(kbd_clk_oe), 32'd1);
        kbd_data_in = 1'b1;
        kbd_clk_in = 1'b0;
        tick(100);
        kbd_clk_in = 1'b1;
        tick(20);
        pb6_clk_enable = 1'b1;
        tick(5);
        check("pb6_clk_oe_off", 32'(kbd_clk_oe), 32'd0);
        check("pb6_state", 32'(dut.state), 32'(IDLE));
        check("pb6_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        check("pb6_irq1", 32'(irq1), 32'd0);

        fe_base = fe_count;
        kbd_bit(1'b1);
        kbd_bit(1'b0);
        kbd_bit(1'b1);
        kbd_bit(1'b1);
        kbd_bit(1'b0);
        check("pre_rst_state", 32'(dut.state), 32'(SHIFT));
        reset = 1'b1;
        tick(2);
        check("mid_rst_scancode", 32'(scancode), 32'h00);
        check("mid_rst_irq1", 32'(irq1), 32'd0);
        check("mid_rst_data_oe", 32'(kbd_data_oe), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        reset = 1'b0;
        tick(5);
        check("mid_rst_no_ferr", 32'(fe_count - fe_base), 32'd0);
        send_frame(8'h1C, 1'b0);
        check("rst_next_code", 32'(scancode), 32'h1C);
        check("rst_next_irq1", 32'(irq1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
